key_sched_ctrl: RTL and testbench

KEY_SCHED_CTRL -- requirements
Module: key_sched_ctrl

---
 rtl/key_sched_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_key_sched_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_sched_ctrl.sv
// rtl/key_sched_ctrl.sv - AES-128 key schedule controller with an 11-entry round-key store
//
// Expands a 128-bit cipher key into the 11 AES-128 round keys using one shared
// round-function instance (4 S-boxes). The keys are produced one per cycle, so a
// full expansion takes 10 cycles.
//
// Optional feature: define KEY_SCHED_ZEROIZE_EN to add the synchronous clear port.
// Without it the clear port and its logic are absent.
//
// Ports:
//   clk       in   1    clock, rising edge
//   rst_n     in   1    asynchronous reset, active HIGH despite the name
//   start     in   1    expand key_in (honoured in IDLE or READY only)
//   key_in    in   128  cipher key, word w0 in [127:96]
//   rd_round  in   4    round-key index to read (0..10 valid)
//   clear     in   1    zeroize request (only with KEY_SCHED_ZEROIZE_EN)
//   rd_key    out  128  round key kst[rd_round], 0 when rd_round > 10
//   rd_valid  out  1    rd_key holds a key generated from the current cipher key
//   busy      out  1    high while expanding
//   done      out  1    one-cycle pulse after round key 10 is written

module key_sched_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic [3:0]   rd_round,
`ifdef KEY_SCHED_ZEROIZE_EN
  input  logic         clear,
`endif
  output logic [127:0] rd_key,
  output logic         rd_valid,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  // AES forward S-box, index 0 is the leftmost byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [7:0] rcon_of(input logic [3:0] n);
    logic [7:0] r;
    case (n)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  state_t       state;
  logic [3:0]   cnt;
  logic [127:0] kst [0:10];

  // ---------------------------------------------------------------------------
  // Single shared round function, fed from kst[cnt]
  // ---------------------------------------------------------------------------
  logic [127:0] rk_cur;
  logic [127:0] rk_nxt;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot, tem;
  logic [31:0]  n0, n1, n2, n3;

  // cnt can sit at 10 outside EXPAND; the compare-mux keeps the read in range.
  always_comb begin
    rk_cur = '0;
    for (int i = 0; i <= 10; i++) begin
      if (cnt == 4'(i)) rk_cur = kst[i];
    end
  end

  always_comb begin
    w0  = rk_cur[127:96];
    w1  = rk_cur[95:64];
    w2  = rk_cur[63:32];
    w3  = rk_cur[31:0];
    rot = {w3[23:0], w3[31:24]};
    tem = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    n0  = w0 ^ tem ^ {rcon_of(cnt), 24'h000000};
    n1  = w1 ^ n0;
    n2  = w2 ^ n1;
    n3  = w3 ^ n2;
    rk_nxt = {n0, n1, n2, n3};
  end

  // ---------------------------------------------------------------------------
  // Control FSM and key store
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      for (int i = 0; i <= 10; i++) kst[i] <= '0;
    end else begin
      done <= 1'b0;
`ifdef KEY_SCHED_ZEROIZE_EN
      if (clear) begin
        // Zeroize beats a simultaneous start and suppresses any done pulse.
        state <= IDLE;
        cnt   <= 4'd0;
        busy  <= 1'b0;
        for (int i = 0; i <= 10; i++) kst[i] <= '0;
      end else
`endif
      begin
        case (state)
          IDLE, READY: begin
            if (start) begin
              kst[0] <= key_in;
              cnt    <= 4'd0;
              busy   <= 1'b1;
              state  <= EXPAND;
            end
          end
          EXPAND: begin
            for (int i = 1; i <= 10; i++) begin
              if (cnt == 4'(i - 1)) kst[i] <= rk_nxt;
            end
            cnt <= cnt + 4'd1;
            if (cnt == 4'd9) begin
              state <= READY;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read port
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_key = '0;
    for (int i = 0; i <= 10; i++) begin
      if (rd_round == 4'(i)) rd_key = kst[i];
    end
  end

  // During EXPAND only entries up to cnt belong to the new key; entries above
  // still hold the previous schedule and must not be reported valid.
  always_comb begin
    rd_valid = 1'b0;
    if (rd_round <= 4'd10) begin
      if (state == READY)
        rd_valid = 1'b1;
      else if (state == EXPAND && rd_round <= cnt)
        rd_valid = 1'b1;
    end
  end

endmodule

// File: tb/tb_key_sched_ctrl.sv
// tb/tb_key_sched_ctrl.sv - randomized self-checking bench for key_sched_ctrl
module tb_key_sched_ctrl;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic [3:0]   rd_round;
  logic         clear;
  logic [127:0] rd_key;
  logic         rd_valid;
  logic         busy;
  logic         done;

  key_sched_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .rd_round (rd_round),
`ifdef KEY_SCHED_ZEROIZE_EN
    .clear    (clear),
`endif
    .rd_key   (rd_key),
    .rd_valid (rd_valid),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_EXP = 1, M_RDY = 2;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic [7:0]   sbox_t [0:255];
  logic [127:0] m_sched [0:10];
  logic [127:0] m_kst [0:10];
  int           m_mode;
  int           m_cnt;
  logic         m_done;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b};
    return d[15 - n -: 8];
  endfunction

  // S-box from its algebraic definition: GF(2^8) inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      if (x == 0) inv = 8'h00;
      else for (int k = 0; k < 254; k++) inv = gf_mul(inv, 8'(x));
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Word-recursion key expansion: w[i] = w[i-4] ^ f(w[i-1]).
  task automatic build_sched(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) m_sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_cnt  = 0;
    m_done = 1'b0;
    for (int r = 0; r <= 10; r++) m_kst[r] = '0;
  endtask

  task automatic model_edge();
    m_done = 1'b0;
    if (rst_n) begin
      model_reset();
`ifdef KEY_SCHED_ZEROIZE_EN
    end else if (clear) begin
      model_reset();
`endif
    end else if (m_mode != M_EXP && start) begin
      build_sched(key_in);
      m_kst[0] = key_in;
      m_cnt    = 0;
      m_mode   = M_EXP;
    end else if (m_mode == M_EXP) begin
      m_kst[m_cnt + 1] = m_sched[m_cnt + 1];
      if (m_cnt == 9) begin
        m_mode = M_RDY;
        m_done = 1'b1;
      end
      m_cnt++;
    end
  endtask

  task automatic check_all(input string tag);
    int r;
    logic ev;
    r  = int'(rd_round);
    ev = (r <= 10) && (m_mode == M_RDY || (m_mode == M_EXP && r <= m_cnt));
    check_eq({tag, ".busy"}, 128'(busy), 128'(m_mode == M_EXP));
    check_eq({tag, ".done"}, 128'(done), 128'(m_done));
    check_eq({tag, ".rd_valid"}, 128'(rd_valid), 128'(ev));
    check_eq({tag, ".rd_key"}, rd_key, (r <= 10) ? m_kst[r] : 128'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  int done_cnt;
  int done_at;

  initial begin
    rst_n = 1'b0; start = 1'b0; key_in = '0; rd_round = '0; clear = 1'b0;
    build_sbox();
    model_reset();

    // Reset state
    #2 rst_n = 1'b1;
    #1;
    check_eq("rst.busy", 128'(busy), 128'h0);
    check_eq("rst.done", 128'(done), 128'h0);
    check_eq("rst.rd_valid", 128'(rd_valid), 128'h0);
    check_eq("rst.rd_key", rd_key, 128'h0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check_all("idle");

    // FIPS-197 expansion, rd_round=3 polled, stray start in EXPAND cycle 5
    start = 1'b1; key_in = FIPS_KEY; rd_round = 4'd3;
    tick();
    start = 1'b0;
    done_cnt = 0; done_at = -1;
    for (int c = 1; c <= 14; c++) begin
      check_all("fips");
      check_eq($sformatf("fips.poll3.c%0d", c), 128'(rd_valid), 128'(c >= 4));
      if (done) begin
        done_cnt++;
        done_at = c;
      end
      start  = (c == 5);
      key_in = (c == 5) ? 128'h0 : FIPS_KEY;
      tick();
    end
    start = 1'b0;
    check_eq("fips.done_count", 128'(done_cnt), 128'd1);
    check_eq("fips.done_latency", 128'(done_at), 128'd11);
    rd_round = 4'd1;  #1;
    check_eq("fips.rk1", rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
    rd_round = 4'd3;  #1;
    check_eq("fips.rk3", rd_key, 128'h3d80477d4716fe3e1e237e446d7a883b);
    rd_round = 4'd10; #1;
    check_eq("fips.rk10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check_eq("fips.rk10.valid", 128'(rd_valid), 128'h1);
    rd_round = 4'd12; #1;
    check_eq("oob.rd_key", rd_key, 128'h0);
    check_eq("oob.rd_valid", 128'(rd_valid), 128'h0);

    // Re-key from READY: old round keys invalid at once
    start = 1'b1; key_in = {$urandom, $urandom, $urandom, $urandom};
    tick();
    start = 1'b0;
    rd_round = 4'd5; #1;
    check_eq("rekey.old_invalid", 128'(rd_valid), 128'h0);
    rd_round = 4'd0; #1;
    check_eq("rekey.rk0", rd_key, key_in);
    check_eq("rekey.rk0.valid", 128'(rd_valid), 128'h1);

    // Asynchronous reset mid-EXPAND at cnt=6
    for (int c = 0; c < 6; c++) begin
      check_all("rekey");
      tick();
    end
    check_eq("midrst.cnt6_busy", 128'(busy), 128'h1);
    #2 rst_n = 1'b1;
    model_reset();
    #1;
    check_eq("midrst.busy", 128'(busy), 128'h0);
    check_eq("midrst.rd_valid", 128'(rd_valid), 128'h0);
    check_eq("midrst.rd_key0", rd_key, 128'h0);
    tick();
    #1 rst_n = 1'b0;
    tick();
    check_all("after_rst");

`ifdef KEY_SCHED_ZEROIZE_EN
    // clear together with start in READY
    start = 1'b1; key_in = FIPS_KEY;
    tick();
    start = 1'b0;
    for (int c = 0; c < 11; c++) tick();
    check_all("pre_clear");
    clear = 1'b1; start = 1'b1; key_in = {$urandom, $urandom, $urandom, $urandom};
    tick();
    clear = 1'b0; start = 1'b0;
    for (int r = 0; r <= 10; r++) begin
      rd_round = 4'(r); #1;
      check_eq($sformatf("clear.kst%0d", r), rd_key, 128'h0);
    end
    check_eq("clear.busy", 128'(busy), 128'h0);
    check_eq("clear.rd_valid", 128'(rd_valid), 128'h0);
    for (int c = 0; c < 3; c++) begin
      check_eq("clear.no_done", 128'(done), 128'h0);
      tick();
    end
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      start    = ($urandom_range(0, 7) == 0);
      key_in   = {$urandom, $urandom, $urandom, $urandom};
      rd_round = 4'($urandom_range(0, 15));
`ifdef KEY_SCHED_ZEROIZE_EN
      clear    = ($urandom_range(0, 39) == 0);
`endif
      #1;
      check_all("rand");
      tick();
    end
    start = 1'b0; clear = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
